// File: rtl/csr_file_pkg.sv
// csr_file_pkg: shared definitions for the CSR file slice.
//   - CSR addresses implemented by csr_file
//   - exception code constants carried on the writeback CSR bus
//   - Wcsr_BUS layout (field offsets and a packed struct view)
//   - per-CSR software-writable bit masks and reset values
//   - csr_merge(): masked read-modify-write helper
package csr_file_pkg;

  // Wcsr_BUS layout; the width matches the existing `Wcsr_BUS_Wid define.
  localparam int unsigned WCSR_BUS_WID   = 153;
  localparam int unsigned WB_EX          = 152;
  localparam int unsigned WB_ECODE_LSB   = 144;
  localparam int unsigned WB_ESUBCODE    = 143;
  localparam int unsigned WB_CSR_WE      = 142;
  localparam int unsigned WB_ADDR_LSB    = 128;
  localparam int unsigned WB_WMASK_LSB   = 96;
  localparam int unsigned WB_WDATA_LSB   = 64;
  localparam int unsigned WB_PC_LSB      = 32;
  localparam int unsigned WB_VADDR_LSB   = 0;

  typedef struct packed {
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
    logic        csr_we;
    logic [13:0] csr_addr;
    logic [31:0] wmask;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] vaddr;
  } wcsr_bus_t;

  // CSR addresses
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // Exception codes
  localparam logic [7:0] ECODE_INT  = 8'h00;
  localparam logic [7:0] ECODE_PIL  = 8'h01;
  localparam logic [7:0] ECODE_PIS  = 8'h02;
  localparam logic [7:0] ECODE_PIF  = 8'h03;
  localparam logic [7:0] ECODE_PME  = 8'h04;
  localparam logic [7:0] ECODE_PPI  = 8'h07;
  localparam logic [7:0] ECODE_ADE  = 8'h08;
  localparam logic [7:0] ECODE_ALE  = 8'h09;
  localparam logic [7:0] ECODE_SYS  = 8'h0B;
  localparam logic [7:0] ECODE_BRK  = 8'h0C;
  localparam logic [7:0] ECODE_INE  = 8'h0D;
  localparam logic [7:0] ECODE_IPE  = 8'h0E;
  localparam logic [7:0] ECODE_FPD  = 8'h0F;
  localparam logic [7:0] ECODE_TLBR = 8'h3F;

  // Software-writable bits of each CSR word
  localparam logic [31:0] CRMD_WMASK   = 32'h0000_001F;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;  // LIE[10] reserved
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;  // only IS[1:0]
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;

  localparam logic [31:0] CRMD_RST = 32'h0000_0008;      // DA=1

  // ESTAT field positions
  localparam int unsigned ESTAT_TI_BIT = 11;

  function automatic logic [31:0] csr_merge(
    input logic [31:0] old_val,
    input logic [31:0] wdata,
    input logic [31:0] wmask,
    input logic [31:0] writable
  );
    logic [31:0] m;
    m = wmask & writable;
    return (old_val & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/csr_file_timer.sv
// csr_timer: TCFG/TVAL constant timer.
//   clk, rstn  : clock, synchronous active-low reset
//   tcfg_we    : committed write to TCFG this cycle
//   wmask/wdata: write mask and data (low TIMER_W bits of the bus)
//   tcfg       : TCFG register {InitVal, Periodic, En}
//   tval       : current count value
//   ti_set     : timer expiry this cycle (sets ESTAT.IS[11] at the edge)
module csr_timer #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tcfg_we,
  input  logic [TIMER_W-1:0] wmask,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               ti_set
);

  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;

  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    // Expiry is judged on the registered state, so it still fires on an
    // edge that also carries a TCFG write; the write only decides TCFG/TVAL.
    ti_set = tcfg_q[0] && (tval_q == '0);
    if (tcfg_we) begin
      tcfg_d = (tcfg_q & ~wmask) | (wdata & wmask);
      tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q != '0) begin
        tval_d = tval_q - TIMER_W'(1);
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
      end else begin
        tcfg_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tcfg_q <= '0;
      tval_q <= '0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
    end
  end

  assign tcfg = tcfg_q;
  assign tval = tval_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: architectural exception/timer CSRs at the writeback end of the
// pipeline. Commits CSR writes, exceptions and ERTN from the Wcsr_BUS.
//   clk, rstn  : clock, synchronous active-low reset
//   Wcsr_BUS   : writeback CSR/exception bus (ex, csr_we valid-qualified)
//   ertn_W     : ERTN committing in writeback
//   hw_int     : external interrupt lines (registered into ESTAT.IS[9:2])
//   csr_raddr  : decode read address
//   csr_rdata  : combinational read data, 0 for unimplemented addresses
//   has_int    : enabled interrupt pending (registered state only)
//   ex_en      : pipeline flush (exception or ERTN this cycle)
//   ex_entry   : redirect PC (EENTRY on exception, ERA on ERTN)
//   crmd_plv   : current privilege level
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] EENTRY_RST = 32'h0000_0000,
  parameter logic [31:0] TID_RST    = 32'h0000_0000,
  parameter int unsigned TIMER_W    = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [WCSR_BUS_WID-1:0] Wcsr_BUS,
  input  logic                    ertn_W,
  input  logic [7:0]              hw_int,
  input  logic [13:0]             csr_raddr,
  output logic [31:0]             csr_rdata,
  output logic                    has_int,
  output logic                    ex_en,
  output logic [31:0]             ex_entry,
  output logic [1:0]              crmd_plv
);

  wcsr_bus_t bus;
  assign bus = wcsr_bus_t'(Wcsr_BUS);

  logic [31:0] crmd_q,   crmd_d;
  logic [31:0] prmd_q,   prmd_d;
  logic [31:0] ecfg_q,   ecfg_d;
  logic [31:0] estat_q,  estat_d;
  logic [31:0] era_q,    era_d;
  logic [31:0] badv_q,   badv_d;
  logic [31:0] eentry_q, eentry_d;
  logic [31:0] tid_q,    tid_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];

  logic               csr_wr;
  logic               ertn_commit;
  logic               tcfg_we;
  logic               ticlr_clr;
  logic               ti_set;
  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] tval;

  // A committing exception suppresses both the CSR write and ERTN on its beat.
  assign csr_wr      = bus.csr_we && !bus.ex;
  assign ertn_commit = ertn_W && !bus.ex;
  assign tcfg_we     = csr_wr && (bus.csr_addr == CSR_TCFG);
  assign ticlr_clr   = csr_wr && (bus.csr_addr == CSR_TICLR)
                       && bus.wdata[0] && bus.wmask[0];

  csr_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .tcfg_we (tcfg_we),
    .wmask   (bus.wmask[TIMER_W-1:0]),
    .wdata   (bus.wdata[TIMER_W-1:0]),
    .tcfg    (tcfg),
    .tval    (tval),
    .ti_set  (ti_set)
  );

  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    estat_d  = estat_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    tid_d    = tid_q;
    save_d   = save_q;

    if (csr_wr) begin
      case (bus.csr_addr)
        CSR_CRMD:   crmd_d   = csr_merge(crmd_q, bus.wdata, bus.wmask, CRMD_WMASK);
        CSR_PRMD:   prmd_d   = csr_merge(prmd_q, bus.wdata, bus.wmask, PRMD_WMASK);
        CSR_ECFG:   ecfg_d   = csr_merge(ecfg_q, bus.wdata, bus.wmask, ECFG_WMASK);
        CSR_ESTAT:  estat_d  = csr_merge(estat_q, bus.wdata, bus.wmask, ESTAT_WMASK);
        CSR_ERA:    era_d    = csr_merge(era_q, bus.wdata, bus.wmask, '1);
        CSR_BADV:   badv_d   = csr_merge(badv_q, bus.wdata, bus.wmask, '1);
        CSR_EENTRY: eentry_d = csr_merge(eentry_q, bus.wdata, bus.wmask, EENTRY_WMASK);
        CSR_TID:    tid_d    = csr_merge(tid_q, bus.wdata, bus.wmask, '1);
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
          save_d[bus.csr_addr[1:0]] =
            csr_merge(save_q[bus.csr_addr[1:0]], bus.wdata, bus.wmask, '1);
        default: ;
      endcase
    end

    // Hardware-owned ESTAT fields; expiry takes priority over a TICLR clear.
    estat_d[9:2] = hw_int;
    if (ticlr_clr) estat_d[ESTAT_TI_BIT] = 1'b0;
    if (ti_set)    estat_d[ESTAT_TI_BIT] = 1'b1;

    if (ertn_commit) begin
      crmd_d[1:0] = prmd_q[1:0];
      crmd_d[2]   = prmd_q[2];
    end

    if (bus.ex) begin
      prmd_d[1:0]    = crmd_q[1:0];
      prmd_d[2]      = crmd_q[2];
      crmd_d[2:0]    = 3'b000;
      era_d          = bus.pc;
      estat_d[21:16] = bus.ecode[5:0];
      estat_d[30:22] = {8'b0, bus.esubcode};
      if (bus.ecode == ECODE_ADE && !bus.esubcode) begin
        badv_d = bus.pc;
      end else if (bus.ecode == ECODE_ADE || bus.ecode == ECODE_ALE) begin
        badv_d = bus.vaddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      crmd_q   <= CRMD_RST;
      prmd_q   <= '0;
      ecfg_q   <= '0;
      estat_q  <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= EENTRY_RST & EENTRY_WMASK;
      tid_q    <= TID_RST;
      for (int unsigned i = 0; i < 4; i++) save_q[i] <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      for (int unsigned i = 0; i < 4; i++) save_q[i] <= save_d[i];
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      CSR_CRMD:   csr_rdata = crmd_q;
      CSR_PRMD:   csr_rdata = prmd_q;
      CSR_ECFG:   csr_rdata = ecfg_q;
      CSR_ESTAT:  csr_rdata = estat_q;
      CSR_ERA:    csr_rdata = era_q;
      CSR_BADV:   csr_rdata = badv_q;
      CSR_EENTRY: csr_rdata = eentry_q;
      CSR_SAVE0:  csr_rdata = save_q[0];
      CSR_SAVE1:  csr_rdata = save_q[1];
      CSR_SAVE2:  csr_rdata = save_q[2];
      CSR_SAVE3:  csr_rdata = save_q[3];
      CSR_TID:    csr_rdata = tid_q;
      CSR_TCFG:   csr_rdata = 32'(tcfg);
      CSR_TVAL:   csr_rdata = 32'(tval);
      default:    csr_rdata = '0;
    endcase
  end

  assign has_int  = crmd_q[2] && |(estat_q[12:0] & ecfg_q[12:0]);
  assign ex_en    = bus.ex || ertn_W;
  assign ex_entry = bus.ex ? eentry_q : era_q;
  assign crmd_plv = crmd_q[1:0];

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

  logic         clk = 1'b0;
  logic         rstn;
  logic [152:0] wcsr_bus;
  logic         ertn_w;
  logic [7:0]   hw_int;
  logic [13:0]  csr_raddr;
  logic [31:0]  csr_rdata;
  logic         has_int;
  logic         ex_en;
  logic [31:0]  ex_entry;
  logic [1:0]   crmd_plv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  csr_file #(
    .EENTRY_RST (32'h0000_0000),
    .TID_RST    (32'h0000_00A5),
    .TIMER_W    (32)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .Wcsr_BUS  (wcsr_bus),
    .ertn_W    (ertn_w),
    .hw_int    (hw_int),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .has_int   (has_int),
    .ex_en     (ex_en),
    .ex_entry  (ex_entry),
    .crmd_plv  (crmd_plv)
  );

  function automatic logic [152:0] wr_beat(input logic [13:0] a, input logic [31:0] m,
                                           input logic [31:0] d);
    return {1'b0, 8'h00, 1'b0, 1'b1, a, m, d, 32'h0, 32'h0};
  endfunction

  function automatic logic [152:0] ex_beat(input logic [7:0] ec, input logic es,
                                           input logic [31:0] pc, input logic [31:0] va);
    return {1'b1, ec, es, 1'b0, 14'h0, 32'h0, 32'h0, pc, va};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    csr_raddr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic do_write(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
    wcsr_bus = wr_beat(a, m, d);
    tick();
    wcsr_bus = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rd(14'h000, d); n_tests++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL reset_crmd: got %h want %h", d, 32'h8); end
    rd(14'h042, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_tval: got %h want 0", d); end
    rd(14'h040, d); n_tests++;
    if (d !== 32'hA5) begin n_fail++; $display("FAIL reset_tid: got %h want a5", d); end
    rd(14'h045, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unimpl_read: got %h want 0", d); end
    n_tests++;
    if (has_int !== 1'b0 || ex_en !== 1'b0 || crmd_plv !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: has_int=%b ex_en=%b plv=%0d want 0 0 0", has_int, ex_en, crmd_plv);
    end
  endtask

  task automatic test_save_write();
    logic [31:0] d;
    wcsr_bus = wr_beat(14'h030, 32'hFFFF_0000, 32'h1234_5678);
    rd(14'h030, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL save0_no_bypass: got %h want 0", d); end
    tick();
    wcsr_bus = '0;
    rd(14'h030, d); n_tests++;
    if (d !== 32'h1234_0000) begin n_fail++; $display("FAIL save0_masked: got %h want 12340000", d); end
    do_write(14'h033, 32'hFFFF_FFFF, 32'hA5A5_5A5A);
    rd(14'h033, d); n_tests++;
    if (d !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL save3_full: got %h want a5a55a5a", d); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    do_write(14'h000, 32'hFFFF_FFFF, 32'h0000_0007);
    do_write(14'h00C, 32'hFFFF_FFFF, 32'h1C00_803F);
    rd(14'h00C, d); n_tests++;
    if (d !== 32'h1C00_8000) begin n_fail++; $display("FAIL eentry_low_zero: got %h want 1c008000", d); end
    wcsr_bus = ex_beat(8'h09, 1'b0, 32'h1C00_0100, 32'h0000_0003);
    #1; n_tests++;
    if (ex_en !== 1'b1 || ex_entry !== 32'h1C00_8000) begin
      n_fail++; $display("FAIL ex_redirect: ex_en=%b entry=%h want 1 1c008000", ex_en, ex_entry);
    end
    tick();
    wcsr_bus = '0;
    rd(14'h006, d); n_tests++;
    if (d !== 32'h1C00_0100) begin n_fail++; $display("FAIL ex_era: got %h want 1c000100", d); end
    rd(14'h007, d); n_tests++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL ex_badv_ale: got %h want 3", d); end
    rd(14'h001, d); n_tests++;
    if (d !== 32'h7) begin n_fail++; $display("FAIL ex_prmd: got %h want 7", d); end
    rd(14'h000, d); n_tests++;
    if (d !== 32'h0 || crmd_plv !== 2'd0) begin n_fail++; $display("FAIL ex_crmd: got %h plv %0d want 0 0", d, crmd_plv); end
    rd(14'h005, d); n_tests++;
    if (d !== 32'h0009_0000) begin n_fail++; $display("FAIL ex_estat: got %h want 00090000", d); end
  endtask

  task automatic test_ertn();
    logic [31:0] d;
    ertn_w = 1'b1;
    #1; n_tests++;
    if (ex_en !== 1'b1 || ex_entry !== 32'h1C00_0100) begin
      n_fail++; $display("FAIL ertn_redirect: ex_en=%b entry=%h want 1 1c000100", ex_en, ex_entry);
    end
    tick();
    ertn_w = 1'b0;
    rd(14'h000, d); n_tests++;
    if (d !== 32'h7 || crmd_plv !== 2'd3) begin n_fail++; $display("FAIL ertn_crmd: got %h plv %0d want 7 3", d, crmd_plv); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic [31:0] exp_tv;
    do_write(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
    do_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0007);
    rd(14'h042, d); n_tests++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL tval_load: got %h want 4", d); end
    for (int k = 3; k >= 0; k--) begin
      tick();
      exp_tv = 32'(k);
      rd(14'h042, d); n_tests++;
      if (d !== exp_tv) begin n_fail++; $display("FAIL tval_count: got %h want %h", d, exp_tv); end
    end
    n_tests++;
    if (has_int !== 1'b0) begin n_fail++; $display("FAIL int_before_expiry: got %b want 0", has_int); end
    tick();
    rd(14'h005, d); n_tests++;
    if (d !== 32'h0009_0800) begin n_fail++; $display("FAIL ti_set: estat %h want 00090800", d); end
    rd(14'h042, d); n_tests++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL tval_reload: got %h want 4", d); end
    n_tests++;
    if (has_int !== 1'b1) begin n_fail++; $display("FAIL timer_has_int: got %b want 1", has_int); end
    do_write(14'h044, 32'h0000_0001, 32'h0000_0001);
    rd(14'h005, d); n_tests++;
    if (d !== 32'h0009_0000) begin n_fail++; $display("FAIL ticlr: estat %h want 00090000", d); end
    rd(14'h044, d); n_tests++;
    if (d !== 32'h0 || has_int !== 1'b0) begin n_fail++; $display("FAIL ticlr_read: got %h has_int %b want 0 0", d, has_int); end
    tick(); tick(); tick();
    rd(14'h042, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL tval_zero_again: got %h want 0", d); end
    do_write(14'h044, 32'h0000_0001, 32'h0000_0001);
    rd(14'h005, d); n_tests++;
    if (d !== 32'h0009_0800) begin n_fail++; $display("FAIL expiry_beats_ticlr: estat %h want 00090800", d); end
    do_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0000);
    do_write(14'h044, 32'h0000_0001, 32'h0000_0001);
    do_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0005);
    tick(); tick(); tick(); tick();
    rd(14'h005, d); n_tests++;
    if (d !== 32'h0009_0000) begin n_fail++; $display("FAIL oneshot_pre: estat %h want 00090000", d); end
    tick();
    rd(14'h005, d); n_tests++;
    if (d !== 32'h0009_0800) begin n_fail++; $display("FAIL oneshot_ti: estat %h want 00090800", d); end
    rd(14'h041, d); n_tests++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL oneshot_en_clear: tcfg %h want 4", d); end
    tick();
    rd(14'h042, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL oneshot_hold: tval %h want 0", d); end
    do_write(14'h044, 32'h0000_0001, 32'h0000_0001);
  endtask

  task automatic test_ex_with_we();
    logic [31:0] d;
    wcsr_bus = {1'b1, 8'h08, 1'b0, 1'b1, 14'h031, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                32'h1C00_0200, 32'h1234_5678};
    tick();
    wcsr_bus = '0;
    rd(14'h031, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ex_blocks_we: save1 %h want 0", d); end
    rd(14'h007, d); n_tests++;
    if (d !== 32'h1C00_0200) begin n_fail++; $display("FAIL adef_badv_pc: got %h want 1c000200", d); end
    rd(14'h005, d); n_tests++;
    if (d !== 32'h0008_0000) begin n_fail++; $display("FAIL adef_estat: got %h want 00080000", d); end
    rd(14'h001, d); n_tests++;
    if (d !== 32'h7) begin n_fail++; $display("FAIL adef_prmd: got %h want 7", d); end
    wcsr_bus = ex_beat(8'h0B, 1'b1, 32'h1C00_0300, 32'hFFFF_0000);
    ertn_w   = 1'b1;
    #1; n_tests++;
    if (ex_entry !== 32'h1C00_8000) begin n_fail++; $display("FAIL ex_over_ertn_entry: got %h want 1c008000", ex_entry); end
    tick();
    wcsr_bus = '0;
    ertn_w   = 1'b0;
    rd(14'h000, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ex_over_ertn_crmd: got %h want 0", d); end
    rd(14'h001, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL sys_prmd: got %h want 0", d); end
    rd(14'h007, d); n_tests++;
    if (d !== 32'h1C00_0200) begin n_fail++; $display("FAIL sys_badv_hold: got %h want 1c000200", d); end
    rd(14'h005, d); n_tests++;
    if (d !== 32'h004B_0000) begin n_fail++; $display("FAIL sys_estat: got %h want 004b0000", d); end
  endtask

  task automatic test_hw_int();
    logic [31:0] d;
    do_write(14'h004, 32'hFFFF_FFFF, 32'h0000_1FFF);
    rd(14'h004, d); n_tests++;
    if (d !== 32'h0000_1BFF) begin n_fail++; $display("FAIL ecfg_bit10: got %h want 00001bff", d); end
    do_write(14'h000, 32'hFFFF_FFFF, 32'h0000_0004);
    hw_int = 8'hA5;
    #1; n_tests++;
    if (has_int !== 1'b0) begin n_fail++; $display("FAIL hw_int_comb_path: got %b want 0", has_int); end
    tick();
    rd(14'h005, d); n_tests++;
    if (d !== 32'h004B_0294 || has_int !== 1'b1) begin
      n_fail++; $display("FAIL hw_int_reg: estat %h has_int %b want 004b0294 1", d, has_int);
    end
    hw_int = 8'h00;
    tick(); n_tests++;
    if (has_int !== 1'b0) begin n_fail++; $display("FAIL hw_int_drop: got %b want 0", has_int); end
    do_write(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h005, d); n_tests++;
    if (d !== 32'h004B_0003 || has_int !== 1'b1) begin
      n_fail++; $display("FAIL sw_int: estat %h has_int %b want 004b0003 1", d, has_int);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    do_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0007);
    rstn     = 1'b0;
    wcsr_bus = wr_beat(14'h030, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    tick();
    wcsr_bus = '0;
    rd(14'h000, d); n_tests++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL rst_crmd: got %h want 8", d); end
    rd(14'h030, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_save0: got %h want 0", d); end
    rd(14'h00C, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_eentry: got %h want 0", d); end
    rd(14'h005, d); n_tests++;
    if (d !== 32'h0 || has_int !== 1'b0) begin n_fail++; $display("FAIL rst_estat: got %h has_int %b want 0 0", d, has_int); end
    rstn = 1'b1;
    tick();
    rd(14'h042, d); n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_tval: got %h want 0", d); end
  endtask

  initial begin
    rstn      = 1'b0;
    wcsr_bus  = '0;
    ertn_w    = 1'b0;
    hw_int    = 8'h00;
    csr_raddr = 14'h0;
    tick();
    tick();
    test_reset();
    rstn = 1'b1;
    tick();
    test_save_write();
    test_exception();
    test_ertn();
    test_timer();
    test_ex_with_we();
    test_hw_int();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
